// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg: shared ALU op indices, IR field positions, CON condition codes, opcodes and branch-condition helper
package cpu_datapath_pkg;
  localparam int ALU_OPS = 13;
  localparam int OP_AND = 0;
  localparam int OP_OR = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_MUL = 4;
  localparam int OP_DIV = 5;
  localparam int OP_SHR = 6;
  localparam int OP_SHRA = 7;
  localparam int OP_SHL = 8;
  localparam int OP_ROR = 9;
  localparam int OP_ROL = 10;
  localparam int OP_NEG = 11;
  localparam int OP_NOT = 12;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam int C_MSB = 18;
  localparam int COND_LSB = 19;
  typedef enum logic [1:0] {CON_EQ, CON_NE, CON_GE, CON_LT} con_t;
  typedef enum logic [4:0] {
    OPC_LD, OPC_LDI, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
    OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL, OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_DIV,
    OPC_MUL, OPC_NEG, OPC_NOT, OPC_BR, OPC_JR, OPC_JAL, OPC_IN, OPC_OUT,
    OPC_MFHI, OPC_MFLO, OPC_NOP, OPC_HALT
  } opcode_t;
  function automatic logic con_eval(con_t cond, logic [31:0] v);
    return cond == CON_EQ ? v == '0 : cond == CON_NE ? v != '0 : cond == CON_GE ? !v[31] : v[31];
  endfunction
endpackage

// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: per-cycle control enables (bus selects, ALU ops, loads, memory) plus IN/OUT ports; master=control unit, slave=datapath
interface cpu_datapath_if;
  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic Read, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic read_mem, write_mem, CON_RESET, PCSave;
  logic [31:0] IN_unit_input, OUT_unit_output;
  modport master (
    output HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout,
    output Read, IncPC, AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
    output read_mem, write_mem, CON_RESET, PCSave, IN_unit_input,
    input OUT_unit_output
  );
  modport slave (
    input HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout,
    input Read, IncPC, AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input Gra, Grb, Grc, Rin, Rout, BAout,
    input HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
    input read_mem, write_mem, CON_RESET, PCSave, IN_unit_input,
    output OUT_unit_output
  );
endinterface

// File: rtl/cpu_datapath_alu.sv
// cpu_alu: one-hot ALU, z = op(y, b) as 64 bits (MUL/DIV fill the high word, everything else leaves it 0)
import cpu_datapath_pkg::*;
module cpu_alu (
  input  logic [31:0] y,
  input  logic [31:0] b,
  input  logic [ALU_OPS-1:0] op,
  output logic [63:0] z
);
  logic signed [31:0] ys, bs, q, r, sra;
  logic [63:0] prod, rr, rl;
  logic [31:0] lo;
  assign ys = y;
  assign bs = b;
  assign prod = {{32{y[31]}}, y} * {{32{b[31]}}, b};
  assign q = ys / bs;
  assign r = ys % bs;
  assign sra = ys >>> b[4:0];
  assign rr = {y, y} >> b[4:0];
  assign rl = {y, y} << b[4:0];
  assign lo = op[OP_AND] ? y & b : op[OP_OR] ? y | b : op[OP_ADD] ? y + b : op[OP_SUB] ? y - b :
              op[OP_SHR] ? y >> b[4:0] : op[OP_SHRA] ? sra : op[OP_SHL] ? y << b[4:0] :
              op[OP_ROR] ? rr[31:0] : op[OP_ROL] ? rl[63:32] : op[OP_NEG] ? -b : op[OP_NOT] ? ~b : '0;
  assign z = op[OP_MUL] ? prod : op[OP_DIV] ? (b == '0 ? '0 : {r, q}) : {32'b0, lo};
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath (R0-R15, PC/IR/MAR/MDR, Y/Z, HI/LO, ALU, RAM, CON, IN/OUT); clk, reset, control interface c
import cpu_datapath_pkg::*;
module cpu_datapath #(
  parameter int MEM_WORDS = 512
) (
  input logic clk,
  input logic reset,
  cpu_datapath_if.slave c
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] r [16];
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo, in_reg, out_reg, bus, rsel, c_ext, mem_rd;
  logic [63:0] z, alu_z;
  logic [3:0] idx;
  logic [ALU_OPS-1:0] op;
  logic con, unused;
  assign idx = ({4{c.Gra}} & ir[RA_LSB +: 4]) | ({4{c.Grb}} & ir[RB_LSB +: 4]) | ({4{c.Grc}} & ir[RC_LSB +: 4]);
  assign rsel = (c.BAout && idx == '0) ? '0 : r[idx];
  assign c_ext = {{(31 - C_MSB){ir[C_MSB]}}, ir[C_MSB:0]};
  assign mem_rd = mem[mar[AW-1:0]];
  assign bus = (c.Rout || c.BAout) ? rsel : c.HIout ? hi : c.LOout ? lo : c.Zhighout ? z[63:32] :
               c.Zlowout ? z[31:0] : c.PCout ? pc : c.IRout ? ir : c.MDRout ? mdr : c.INout ? in_reg :
               c.Cout ? c_ext : c.Yout ? y : c.MARout ? mar : '0;
  assign op = {c.NOT, c.NEG, c.ROL, c.ROR, c.SHL, c.SHRA, c.SHR, c.DIV, c.MUL, c.SUB, c.ADD, c.OR, c.AND};
  assign c.OUT_unit_output = out_reg;
  assign unused = ^{c.read_mem, mar[31:AW], ir[31:27]};
  cpu_alu u_alu (.y(y), .b(bus), .op(op), .z(alu_z));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      {pc, ir, mar, mdr, y, hi, lo, in_reg, out_reg} <= '0;
      z <= '0;
      con <= 1'b0;
    end else begin
      if (c.Rin) r[idx] <= bus;
      if (c.PCSave) r[15] <= pc;
      if (c.HIin) hi <= z[63:32];
      if (c.LOin) lo <= z[31:0];
      if (c.PCin) pc <= c.IncPC ? pc + 32'd1 : bus;
      if (c.MARin) mar <= c.IncPC ? pc : bus;
      if (c.MDRin) mdr <= c.Read ? mem_rd : bus;
      if (c.IRin) ir <= bus;
      if (c.Yin) y <= bus;
      if (c.Zin) z <= alu_z;
      if (c.OUT_Portin) out_reg <= bus;
      in_reg <= c.IN_unit_input;
      if (c.CON_RESET) con <= 1'b0;
      else if (c.CONin) con <= con_eval(con_t'(ir[COND_LSB +: 2]), bus);
    end
  end
  always_ff @(posedge clk) begin
    if (c.write_mem) mem[mar[AW-1:0]] <= mdr;
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: drives step sequences through the control interface and scoreboards values observed on the OUT port
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  typedef struct packed {logic [3:0] k; logic [31:0] y, b, lo, hi;} alu_vec_t;
  alu_vec_t vecs [0:17] = '{
    '{4'd2, 32'd7, 32'd5, 32'd12, 32'd0},
    '{4'd13, 32'd7, 32'd5, 32'd0, 32'd0},
    '{4'd3, 32'd5, 32'd7, 32'hFFFFFFFE, 32'd0},
    '{4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'd0},
    '{4'd1, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 32'd0},
    '{4'd6, 32'h80000000, 32'd4, 32'h08000000, 32'd0},
    '{4'd6, 32'h80000000, 32'h21, 32'h40000000, 32'd0},
    '{4'd7, 32'h80000000, 32'd1, 32'hC0000000, 32'd0},
    '{4'd8, 32'd3, 32'd4, 32'h30, 32'd0},
    '{4'd9, 32'd1, 32'd1, 32'h80000000, 32'd0},
    '{4'd10, 32'h80000001, 32'd1, 32'h00000003, 32'd0},
    '{4'd11, 32'd123, 32'd1, 32'hFFFFFFFF, 32'd0},
    '{4'd12, 32'd0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'd0},
    '{4'd4, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 32'hFFFFFFFF},
    '{4'd4, 32'h00010000, 32'h00010000, 32'd0, 32'd1},
    '{4'd5, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF},
    '{4'd5, 32'd7, 32'd0, 32'd0, 32'd0},
    '{4'd5, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2}
  };
  cpu_datapath_if cif();
  cpu_datapath dut (.clk(clk), .reset(reset), .c(cif));
  always #5 clk = ~clk;
  task automatic clr();
    {cif.HIout, cif.LOout, cif.Zhighout, cif.Zlowout, cif.PCout, cif.IRout, cif.MDRout, cif.INout, cif.Cout, cif.Yout, cif.MARout} = '0;
    {cif.Read, cif.IncPC, cif.AND, cif.OR, cif.ADD, cif.SUB, cif.MUL, cif.DIV, cif.SHR, cif.SHRA, cif.SHL, cif.ROR, cif.ROL, cif.NEG, cif.NOT} = '0;
    {cif.Gra, cif.Grb, cif.Grc, cif.Rin, cif.Rout, cif.BAout} = '0;
    {cif.HIin, cif.LOin, cif.PCin, cif.IRin, cif.Zin, cif.Yin, cif.MARin, cif.MDRin, cif.CONin, cif.OUT_Portin} = '0;
    {cif.read_mem, cif.write_mem, cif.CON_RESET, cif.PCSave} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic peek(string tag, logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    cif.OUT_Portin = 1'b1;
    tick();
    chk(tag_q.pop_front(), cif.OUT_unit_output, exp_q.pop_front());
  endtask
  task automatic put(logic [31:0] v);
    cif.IN_unit_input = v;
    tick();
  endtask
  task automatic memw(logic [31:0] a, logic [31:0] d);
    put(a);
    cif.IN_unit_input = d; cif.INout = 1; cif.MARin = 1; tick();
    cif.INout = 1; cif.MDRin = 1; tick();
    cif.write_mem = 1; tick();
  endtask
  task automatic fetch();
    cif.IncPC = 1; cif.PCin = 1; cif.MARin = 1; tick();
    cif.Read = 1; cif.read_mem = 1; cif.MDRin = 1; tick();
    cif.MDRout = 1; cif.IRin = 1; tick();
  endtask
  task automatic ldi();
    cif.Grb = 1; cif.BAout = 1; cif.Yin = 1; tick();
    cif.Cout = 1; cif.ADD = 1; cif.Zin = 1; tick();
    cif.Zlowout = 1; cif.Gra = 1; cif.Rin = 1; tick();
  endtask
  task automatic set_op(logic [3:0] k);
    {cif.AND, cif.OR, cif.ADD, cif.SUB, cif.MUL, cif.DIV, cif.SHR} = {k == 0, k == 1, k == 2, k == 3, k == 4, k == 5, k == 6};
    {cif.SHRA, cif.SHL, cif.ROR, cif.ROL, cif.NEG, cif.NOT} = {k == 7, k == 8, k == 9, k == 10, k == 11, k == 12};
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    clr();
    cif.IN_unit_input = '0;
    reset = 1; tick(); reset = 0;
    memw(32'd0, 32'h09000005);
    memw(32'd1, 32'h09800006);
    memw(32'd2, 32'h81180000);
    memw(32'd3, 32'hCB000000);
    cif.INout = 1; cif.OUT_Portin = 1; tick();
    chk("out_pre", cif.OUT_unit_output, 32'hCB000000);
    cif.CONin = 1; tick();
    chk("con_pre", {31'b0, dut.con}, 32'd1);
    reset = 1; tick(); reset = 0;
    chk("out_rst", cif.OUT_unit_output, 32'd0);
    chk("con_rst", {31'b0, dut.con}, 32'd0);
    cif.PCout = 1; peek("pc_rst", 32'd0);
    cif.MARout = 1; peek("mar_rst", 32'd0);
    cif.MDRout = 1; peek("mdr_rst", 32'd0);
    cif.IRout = 1; peek("ir_rst", 32'd0);
    fetch(); ldi();
    fetch(); ldi();
    cif.PCout = 1; peek("pc_ldi", 32'd2);
    cif.Gra = 1; cif.Rout = 1; peek("r3_ldi", 32'd6);
    fetch();
    cif.Gra = 1; cif.Rout = 1; peek("r2_ldi", 32'd5);
    cif.Grb = 1; cif.Rout = 1; cif.Yin = 1; tick();
    cif.Gra = 1; cif.Rout = 1; cif.MUL = 1; cif.Zin = 1; tick();
    cif.HIin = 1; cif.LOin = 1; tick();
    cif.Yout = 1; peek("mul_y", 32'd6);
    cif.Zlowout = 1; peek("mul_zlo", 32'd30);
    cif.Zhighout = 1; peek("mul_zhi", 32'd0);
    cif.LOout = 1; peek("mul_lo", 32'd30);
    cif.HIout = 1; peek("mul_hi", 32'd0);
    cif.HIout = 1; cif.LOout = 1; peek("bus_prio", 32'd0);
    fetch();
    cif.Zlowout = 1; cif.Gra = 1; cif.Rin = 1; tick();
    cif.Gra = 1; cif.Rout = 1; peek("mflo_r6", 32'h1E);
    cif.PCout = 1; peek("mflo_pc", 32'd4);
    cif.IRout = 1; peek("mflo_ir", 32'hCB000000);
    put(32'h07800000); cif.INout = 1; cif.IRin = 1; tick();
    put(32'h0000DEAD); cif.INout = 1; cif.Gra = 1; cif.Rin = 1; cif.PCSave = 1; tick();
    cif.Gra = 1; cif.Rout = 1; peek("pcsave_r15", 32'd4);
    put(32'h0); cif.INout = 1; cif.IRin = 1; tick();
    put(32'h55); cif.INout = 1; cif.Gra = 1; cif.Rin = 1; tick();
    cif.Gra = 1; cif.Rout = 1; peek("r0_rout", 32'h55);
    cif.Gra = 1; cif.BAout = 1; peek("r0_baout", 32'd0);
    put(32'h0007FFFF); cif.INout = 1; cif.IRin = 1; tick();
    cif.Cout = 1; peek("c_sext", 32'hFFFFFFFF);
    put(32'hFFFFFFFF); cif.INout = 1; cif.PCin = 1; tick();
    cif.IncPC = 1; cif.PCin = 1; cif.MARin = 1; tick();
    cif.MARout = 1; peek("mar_oldpc", 32'hFFFFFFFF);
    cif.PCout = 1; peek("pc_wrap", 32'd0);
    put(32'h00080000); cif.INout = 1; cif.IRin = 1; tick();
    put(32'd5); cif.INout = 1; cif.CONin = 1; tick();
    chk("con_ne5", {31'b0, dut.con}, 32'd1);
    put(32'd0); cif.INout = 1; cif.CONin = 1; tick();
    chk("con_ne0", {31'b0, dut.con}, 32'd0);
    put(32'd7); cif.INout = 1; cif.CONin = 1; tick();
    cif.INout = 1; cif.CONin = 1; cif.CON_RESET = 1; tick();
    chk("con_reset", {31'b0, dut.con}, 32'd0);
    memw(32'd10, 32'hAB);
    cif.MDRin = 1; tick();
    cif.Read = 1; cif.MDRin = 1; tick();
    cif.MDRout = 1; peek("ram_rd", 32'hAB);
    for (int i = 0; i < 18; i++) begin
      put(vecs[i].y);
      cif.IN_unit_input = vecs[i].b; cif.INout = 1; cif.Yin = 1; tick();
      cif.INout = 1; set_op(vecs[i].k); cif.Zin = 1; tick();
      cif.Zlowout = 1; peek($sformatf("alu%0d_lo", i), vecs[i].lo);
      cif.Zhighout = 1; peek($sformatf("alu%0d_hi", i), vecs[i].hi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
